// File: rtl/rst_seq.sv
// Reset sequencer: releases peripheral reset first, then core reset, and re-runs on soft/watchdog requests.
// Optional macro RST_SEQ_WDT_EN enables the watchdog request input and cause code 2'b10.
module rst_seq #(
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned GAP_CYCLES  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       soft_rst_req,
   input  logic       wdt_rst_req,
   output logic       periph_rst_n,
   output logic       core_rst_n,
   output logic       rst_busy,
   output logic [1:0] rst_cause
);

   localparam int unsigned MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef RST_SEQ_WDT_EN
   localparam logic WDT_EN = 1'b1;
`else
   localparam logic WDT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_ASSERT     = 2'd0,
      ST_REL_PERIPH = 2'd1,
      ST_RUN        = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             wdt_req_s;
   logic             req_s;
   logic [1:0]       req_cause_s;

   // Merge request sources; watchdog outranks soft when both arrive together.
   always_comb begin
      wdt_req_s   = wdt_rst_req & WDT_EN;
      req_s       = soft_rst_req | wdt_req_s;
      if (wdt_req_s) begin
         req_cause_s = 2'b10;
      end else begin
         req_cause_s = 2'b01;
      end
   end

   // Sequencer FSM with registered reset outputs; every state change clears the counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_ASSERT;
         cnt_q        <= CNT_ZERO;
         periph_rst_n <= 1'b0;
         core_rst_n   <= 1'b0;
         rst_busy     <= 1'b1;
         rst_cause    <= 2'b00;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               periph_rst_n <= 1'b0;
               core_rst_n   <= 1'b0;
               rst_busy     <= 1'b1;
               if (req_s) begin
                  cnt_q     <= CNT_ZERO;
                  rst_cause <= req_cause_s;
               end else if (cnt_q == HOLD_LAST) begin
                  state_q      <= ST_REL_PERIPH;
                  periph_rst_n <= 1'b1;
                  cnt_q        <= CNT_ZERO;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            ST_REL_PERIPH: begin
               core_rst_n <= 1'b0;
               rst_busy   <= 1'b1;
               if (req_s) begin
                  state_q      <= ST_ASSERT;
                  periph_rst_n <= 1'b0;
                  cnt_q        <= CNT_ZERO;
                  rst_cause    <= req_cause_s;
               end else if (cnt_q == GAP_LAST) begin
                  state_q    <= ST_RUN;
                  core_rst_n <= 1'b1;
                  rst_busy   <= 1'b0;
                  cnt_q      <= CNT_ZERO;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            ST_RUN: begin
               cnt_q <= CNT_ZERO;
               if (req_s) begin
                  state_q      <= ST_ASSERT;
                  periph_rst_n <= 1'b0;
                  core_rst_n   <= 1'b0;
                  rst_busy     <= 1'b1;
                  rst_cause    <= req_cause_s;
               end else begin
                  periph_rst_n <= 1'b1;
                  core_rst_n   <= 1'b1;
                  rst_busy     <= 1'b0;
               end
            end
            default: begin
               state_q      <= ST_ASSERT;
               cnt_q        <= CNT_ZERO;
               periph_rst_n <= 1'b0;
               core_rst_n   <= 1'b0;
               rst_busy     <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/rst_seq.md
# rst_seq

Reset sequencer directly downstream of the reset synchroniser in the core. Consumes the synchronised active-low reset and produces two ordered reset releases: peripherals/bus first, then the CPU core. Also re-enters the sequence on a software/debug reset request or a watchdog timeout, and records the cause of the last reset for software to read.

## Interface
- HOLD_CYCLES, 16, cycles both outputs stay asserted after reset or request (≥1)
- GAP_CYCLES, 4, cycles between peripheral release and core release (≥1)
- clk  input  1  system clock
- rst_n  input  1  synchronised reset from the synchroniser stage; asynchronous, active-low
- soft_rst_req  input  1  software/debug reset request, sampled each cycle, level or pulse
- wdt_rst_req  input  1  watchdog timeout request, sampled each cycle
- periph_rst_n  output  1  peripheral/bus reset, active-low, registered
- core_rst_n  output  1  CPU core reset, active-low, registered
- rst_busy  output  1  high while a sequence is in progress
- rst_cause  output  2  cause of last reset: 00 external, 01 soft, 10 watchdog, 11 never produced

## Operation
- One clock; reset is asynchronous and active-low (clk, rst_n).
- States: ASSERT, REL_PERIPH, RUN. One counter, wide enough for max(HOLD_CYCLES, GAP_CYCLES); cleared on every state change, so it never wraps.
- rst_n low (asynchronous): state ASSERT, counter 0, periph_rst_n=0, core_rst_n=0, rst_busy=1, rst_cause=00.
- ASSERT: both outputs low. Counter increments each edge; at the edge where counter==HOLD_CYCLES-1 -> REL_PERIPH, periph_rst_n<=1, counter<=0.
- REL_PERIPH: periph high, core low. At the edge where counter==GAP_CYCLES-1 -> RUN, core_rst_n<=1, rst_busy<=0.
- RUN: both high, rst_busy=0; rst_cause holds.
- Request handling: req = soft_rst_req | wdt_rst_req (wdt gated by macro).
  - RUN + req: -> ASSERT, both outputs <=0, rst_busy<=1, counter<=0, cause updated.
  - ASSERT + req: counter<=0 (hold restarts), cause updated.
  - REL_PERIPH + req: -> ASSERT, periph_rst_n<=0, counter<=0, cause updated.
- Cause priority on simultaneous requests: watchdog (10) over soft (01). A held-high request keeps the block in ASSERT indefinitely.
- core_rst_n is never high while periph_rst_n is low.

## Timing
- Outputs are registered; no combinational path from inputs to outputs except the asynchronous rst_n clear.
- Power-up: periph_rst_n rises after the HOLD_CYCLES-th rising edge with rst_n high. core_rst_n and rst_busy fall/rise together GAP_CYCLES edges later (total HOLD_CYCLES+GAP_CYCLES).
- Request sampled at edge N in RUN: outputs low immediately after edge N. periph high after edge N+HOLD_CYCLES. core high after edge N+HOLD_CYCLES+GAP_CYCLES.
- rst_cause updates on the same edge the request is sampled.
- rst_n assertion mid-sequence overrides everything at once and clears cause to 00.

## Configuration
- RST_SEQ_WDT_EN defined: wdt_rst_req is honoured as described and cause 10 is possible.
- Not defined: the wdt_rst_req port remains but is ignored. Only soft requests retrigger, and rst_cause is only 00 or 01.

## Test plan
- Power-up, defaults: release rst_n -> periph_rst_n high after 16th edge, core_rst_n/rst_busy change after 20th edge, rst_cause=00.
- Soft request in RUN, 1-cycle pulse -> both low next cycle, periph high 16 edges later, core 4 after that, rst_cause=01.
- soft+wdt same cycle with RST_SEQ_WDT_EN -> rst_cause=10. Without the macro, wdt alone -> no effect, outputs stay high.
- Soft pulse at counter=2 of REL_PERIPH -> periph_rst_n falls next cycle, full 16+4 sequence restarts.
- Soft request held 50 cycles -> both outputs low throughout. periph high 16 edges after the request drops.
- rst_n asserted at counter=10 of ASSERT after a soft request -> all outputs low, cause 00, full sequence on release.
